// File: rtl/arm_pkg.sv
// Shared ARM-subset encodings: ALU commands, data-processing opcodes, instruction modes, condition codes.
package arm_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // status is {N,Z,C,V}; the reserved 1111 encoding never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    {n, z, c, v} = status;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback port and ID/EX / hazard-unit outputs.
interface id_stage_if #(parameter int DATA_W = 32);

  logic [31:0]       instruction;
  logic [31:0]       PC_in;
  logic [3:0]        status;
  logic              hazard;
  logic              WB_WB_EN;
  logic [3:0]        WB_Dest;
  logic [DATA_W-1:0] WB_Value;

  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              B;
  logic              S;
  logic              imm;
  logic [3:0]        EXE_CMD;
  logic [DATA_W-1:0] Val_Rn;
  logic [DATA_W-1:0] Val_Rm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        Dest;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic              Two_src;
  logic [31:0]       PC_out;

  modport slave (
    input  instruction, PC_in, status, hazard, WB_WB_EN, WB_Dest, WB_Value,
    output WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, EXE_CMD, Val_Rn, Val_Rm,
           shift_operand, signed_imm_24, Dest, src1, src2, Two_src, PC_out
  );

  modport master (
    output instruction, PC_in, status, hazard, WB_WB_EN, WB_Dest, WB_Value,
    input  WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, EXE_CMD, Val_Rn, Val_Rm,
           shift_operand, signed_imm_24, Dest, src1, src2, Two_src, PC_out
  );

endinterface

// File: rtl/id_reg_file.sv
// Architectural registers R0..R14: one write port, two combinational read ports with same-cycle
// writeback bypass; index 15 reads the PC. Synchronous reset loads Ri = i.
module id_reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [3:0]        ra1,
  input  logic [3:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // wa == 15 matches no entry, so writes to the PC index drop out naturally
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst)
        regs[i] <= DATA_W'(i);
      else if (we && wa == 4'(i))
        regs[i] <= wd;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
    logic [DATA_W-1:0] val;
    val = pc;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == 4'(i))
        val = (we && wa == idx) ? wd : regs[i];
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: register file, control decode, condition check against NZCV and bubble insertion.
// Fully combinational apart from the register file writeback.
module id_stage
  import arm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   bus
);

  logic [3:0] cond, opcode, rn, rd, rm;
  logic [1:0] mode;
  logic       i_bit, sl_bit;
  logic       wb_en, mem_r_en, mem_w_en, br, s_flag, imm_flag;
  logic [3:0] exe_cmd;
  logic       kill;

  assign cond   = bus.instruction[31:28];
  assign mode   = bus.instruction[27:26];
  assign i_bit  = bus.instruction[25];
  assign opcode = bus.instruction[24:21];
  assign sl_bit = bus.instruction[20];
  assign rn     = bus.instruction[19:16];
  assign rd     = bus.instruction[15:12];
  assign rm     = bus.instruction[3:0];

  always_comb begin
    exe_cmd  = EXE_NOP;
    wb_en    = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    br       = 1'b0;
    s_flag   = 1'b0;
    imm_flag = 1'b0;
    case (mode)
      MODE_DP: begin
        imm_flag = i_bit;
        wb_en    = 1'b1;
        s_flag   = sl_bit;
        case (opcode)
          OP_MOV: exe_cmd = EXE_MOV;
          OP_MVN: exe_cmd = EXE_MVN;
          OP_ADD: exe_cmd = EXE_ADD;
          OP_ADC: exe_cmd = EXE_ADC;
          OP_SUB: exe_cmd = EXE_SUB;
          OP_SBC: exe_cmd = EXE_SBC;
          OP_AND: exe_cmd = EXE_AND;
          OP_ORR: exe_cmd = EXE_ORR;
          OP_EOR: exe_cmd = EXE_EOR;
          OP_CMP: begin exe_cmd = EXE_SUB; wb_en = 1'b0; s_flag = 1'b1; end
          OP_TST: begin exe_cmd = EXE_AND; wb_en = 1'b0; s_flag = 1'b1; end
          default: begin wb_en = 1'b0; s_flag = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        exe_cmd  = EXE_ADD;
        imm_flag = i_bit;
        if (sl_bit) begin
          mem_r_en = 1'b1;
          wb_en    = 1'b1;
        end else begin
          mem_w_en = 1'b1;
        end
      end
      MODE_BR: br = 1'b1;
      default: ;
    endcase
  end

  // src2/Two_src use the ungated store decode: the hazard unit consumes them to produce
  // hazard, so gating them by hazard would form a combinational loop.
  assign bus.src1    = rn;
  assign bus.src2    = mem_w_en ? rd : rm;
  assign bus.Two_src = (mode == MODE_DP && !i_bit) || mem_w_en;

  id_reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_reg_file (
    .clk (clk),
    .rst (rst),
    .pc  (DATA_W'(bus.PC_in)),
    .we  (bus.WB_WB_EN),
    .wa  (bus.WB_Dest),
    .wd  (bus.WB_Value),
    .ra1 (bus.src1),
    .ra2 (bus.src2),
    .rd1 (bus.Val_Rn),
    .rd2 (bus.Val_Rm)
  );

  assign kill = rst || bus.hazard || !cond_pass(cond, bus.status);

  assign bus.WB_EN    = wb_en    && !kill;
  assign bus.MEM_R_EN = mem_r_en && !kill;
  assign bus.MEM_W_EN = mem_w_en && !kill;
  assign bus.B        = br       && !kill;
  assign bus.S        = s_flag   && !kill;
  assign bus.imm      = imm_flag;
  assign bus.EXE_CMD  = exe_cmd;

  assign bus.shift_operand = bus.instruction[11:0];
  assign bus.signed_imm_24 = bus.instruction[23:0];
  assign bus.Dest          = rd;
  assign bus.PC_out        = bus.PC_in;

endmodule
